// File: rtl/imm_encoder_pkg.sv
// Shared types for the RV64I immediate encoder: op/format enums, opcode and
// funct3 constants, and the op-to-format mapping.
package imm_enc_pkg;

  typedef enum logic [2:0] {
    OP_ADDI = 3'd0,
    OP_LD   = 3'd1,
    OP_SD   = 3'd2,
    OP_BEQ  = 3'd3,
    OP_BNE  = 3'd4,
    OP_LUI  = 3'd5,
    OP_JAL  = 3'd6,
    OP_RSV  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_S = 3'd1,
    FMT_B = 3'd2,
    FMT_U = 3'd3,
    FMT_J = 3'd4
  } fmt_e;

  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADDI = 3'b000;
  localparam logic [2:0] F3_LD   = 3'b011;
  localparam logic [2:0] F3_SD   = 3'b011;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;

  // The reserved op maps to I only so the selection logic has a defined path;
  // its word is forced to zero downstream.
  function automatic fmt_e op_to_fmt(input op_e op);
    fmt_e fmt;
    case (op)
      OP_SD:          fmt = FMT_S;
      OP_BEQ, OP_BNE: fmt = FMT_B;
      OP_LUI:         fmt = FMT_U;
      OP_JAL:         fmt = FMT_J;
      default:        fmt = FMT_I;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/imm_encoder_if.sv
// Request/response bundle for imm_encoder; master drives requests and
// out_ready, slave is the encoder.
interface imm_encoder_if #(
  parameter int XLEN  = 64,
  parameter int REG_W = 5
);

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [REG_W-1:0] in_rd;
  logic [REG_W-1:0] in_rs1;
  logic [REG_W-1:0] in_rs2;
  logic [XLEN-1:0]  in_imm;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_instr;
  logic             out_err;

  modport master (
    output in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_err
  );

  modport slave (
    input  in_valid, in_op, in_rd, in_rs1, in_rs2, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_err
  );

endinterface

// File: rtl/imm_encoder_range_chk.sv
// Combinational check that an immediate is exactly representable in the
// selected instruction format (range, alignment and U-type low bits).
module imm_range_chk
  import imm_enc_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  fmt_e            fmt_i,
  input  logic [XLEN-1:0] imm_i,
  output logic            err_o
);

  logic fitsI;
  logic fitsB;
  logic fitsJ;
  logic fitsU;

  // A signed value fits in N bits when every bit from N-1 upward matches.
  assign fitsI = (&imm_i[XLEN-1:11]) | ~(|imm_i[XLEN-1:11]);
  assign fitsB = (&imm_i[XLEN-1:12]) | ~(|imm_i[XLEN-1:12]);
  assign fitsJ = (&imm_i[XLEN-1:20]) | ~(|imm_i[XLEN-1:20]);
  assign fitsU = (imm_i[11:0] == 12'd0) &&
                 ((&imm_i[XLEN-1:31]) | ~(|imm_i[XLEN-1:31]));

  always_comb begin
    err_o = 1'b0;
    case (fmt_i)
      FMT_I, FMT_S: err_o = !fitsI;
      FMT_B:        err_o = !fitsB || imm_i[0];
      FMT_J:        err_o = !fitsJ || imm_i[0];
      FMT_U:        err_o = !fitsU;
      default:      err_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready encoder packing op, registers and immediate into an
// RV64I word. Define IMM_ENC_RANGE_CHECK_EN to flag unrepresentable immediates.
module imm_encoder
  import imm_enc_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int REG_W = 5
) (
  input logic          clk,
  input logic          reset_n,
  imm_encoder_if.slave bus
);

  op_e              inOp;
  fmt_e             inFmt;
  logic [19:0]      immSel;
  logic             rangeErr;
  logic             inAccept;
  logic             s2Load;

  logic             s1Valid_q, s1Valid_d;
  op_e              s1Op_q;
  logic [REG_W-1:0] s1Rd_q, s1Rs1_q, s1Rs2_q;
  logic [19:0]      s1Imm_q;
  logic             s1Err_q, s1Err_d;

  logic             outValid_q, outValid_d;
  logic [31:0]      outInstr_q, instrD;
  logic             outErr_q;

  assign inOp  = op_e'(bus.in_op);
  assign inFmt = op_to_fmt(inOp);

  // Only the bits each format actually encodes are carried into stage 1.
  always_comb begin
    immSel = '0;
    case (inFmt)
      FMT_I, FMT_S: immSel = {8'd0, bus.in_imm[11:0]};
      FMT_B:        immSel = {8'd0, bus.in_imm[12:1]};
      FMT_U:        immSel = bus.in_imm[31:12];
      FMT_J:        immSel = bus.in_imm[20:1];
      default:      immSel = '0;
    endcase
  end

`ifdef IMM_ENC_RANGE_CHECK_EN
  imm_range_chk #(.XLEN(XLEN)) u_range_chk (
    .fmt_i (inFmt),
    .imm_i (bus.in_imm),
    .err_o (rangeErr)
  );
`else
  assign rangeErr = 1'b0;
`endif

  assign s1Err_d = (inOp == OP_RSV) || rangeErr;

  // Stage 1 may refill in the same cycle its contents move into stage 2.
  assign s2Load       = s1Valid_q && (!outValid_q || bus.out_ready);
  assign bus.in_ready = !s1Valid_q || !outValid_q || bus.out_ready;
  assign inAccept     = bus.in_valid && bus.in_ready;
  assign s1Valid_d    = inAccept ? 1'b1 : (s2Load ? 1'b0 : s1Valid_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1Valid_q <= 1'b0;
      s1Op_q    <= OP_ADDI;
      s1Rd_q    <= '0;
      s1Rs1_q   <= '0;
      s1Rs2_q   <= '0;
      s1Imm_q   <= '0;
      s1Err_q   <= 1'b0;
    end else begin
      s1Valid_q <= s1Valid_d;
      if (inAccept) begin
        s1Op_q  <= inOp;
        s1Rd_q  <= bus.in_rd;
        s1Rs1_q <= bus.in_rs1;
        s1Rs2_q <= bus.in_rs2;
        s1Imm_q <= immSel;
        s1Err_q <= s1Err_d;
      end
    end
  end

  // Unused register fields fall out as zero because they are simply not placed.
  always_comb begin
    instrD = '0;
    case (s1Op_q)
      OP_ADDI: instrD = {s1Imm_q[11:0], s1Rs1_q, F3_ADDI, s1Rd_q, OPC_OPIMM};
      OP_LD:   instrD = {s1Imm_q[11:0], s1Rs1_q, F3_LD, s1Rd_q, OPC_LOAD};
      OP_SD:   instrD = {s1Imm_q[11:5], s1Rs2_q, s1Rs1_q, F3_SD,
                         s1Imm_q[4:0], OPC_STORE};
      OP_BEQ:  instrD = {s1Imm_q[11], s1Imm_q[9:4], s1Rs2_q, s1Rs1_q, F3_BEQ,
                         s1Imm_q[3:0], s1Imm_q[10], OPC_BRANCH};
      OP_BNE:  instrD = {s1Imm_q[11], s1Imm_q[9:4], s1Rs2_q, s1Rs1_q, F3_BNE,
                         s1Imm_q[3:0], s1Imm_q[10], OPC_BRANCH};
      OP_LUI:  instrD = {s1Imm_q, s1Rd_q, OPC_LUI};
      OP_JAL:  instrD = {s1Imm_q[19], s1Imm_q[9:0], s1Imm_q[10], s1Imm_q[18:11],
                         s1Rd_q, OPC_JAL};
      default: instrD = '0;
    endcase
  end

  assign outValid_d = s2Load ? 1'b1 : (bus.out_ready ? 1'b0 : outValid_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outValid_q <= 1'b0;
      outInstr_q <= '0;
      outErr_q   <= 1'b0;
    end else begin
      outValid_q <= outValid_d;
      if (s2Load) begin
        outInstr_q <= instrD;
        outErr_q   <= s1Err_q;
      end
    end
  end

  assign bus.out_valid = outValid_q;
  assign bus.out_instr = outInstr_q;
  assign bus.out_err   = outErr_q;

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Inverse of the immediate sign-extension path: packs an operation, register indices and a 64-bit immediate into a 32-bit RV64I instruction word.
- Used by the test-program builder and the self-modifying/trampoline writer to produce words that the decode and immediate-extraction path will later consume.
- Two-stage valid/ready pipeline, throughput 1 word/cycle.
- Optional range checker flags immediates that cannot be represented in the chosen format.

Parameters:
- XLEN, 64, immediate input width.
- REG_W, 5, register index width.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  request valid.
- in_ready  out  1  stage 1 can accept.
- in_op  in  3  op_e: ADDI=0, LD=1, SD=2, BEQ=3, BNE=4, LUI=5, JAL=6, 7 reserved.
- in_rd  in  REG_W  destination register.
- in_rs1  in  REG_W  source register 1.
- in_rs2  in  REG_W  source register 2.
- in_imm  in  XLEN  signed immediate; byte offset for branches and JAL.
- out_valid  out  1  encoded word valid.
- out_ready  in  1  consumer accepts.
- out_instr  out  32  encoded instruction.
- out_err  out  1  immediate unrepresentable or reserved op; qualified by out_valid.

Behaviour:
- Reset (reset_n low, asynchronous): out_valid=0, out_instr=0, out_err=0, internal stage valids=0. Any in-flight words are discarded. First accept is possible on the first clk edge after reset_n rises.
- Handshake:
  - Transfer occurs when valid&&ready at a rising edge.
  - in_ready = !s1_valid || !out_valid || out_ready. It may depend combinationally on out_ready.
  - out_valid, out_instr and out_err are registered and hold stable while out_valid && !out_ready.
- Latency: a word accepted at edge N appears with out_valid=1 after edge N+1, provided there is no backpressure.
- Stage 1 registers:
  - op, rd, rs1, rs2.
  - Format-selected immediate bits.
  - Range-check result.
- Stage 2 assembles the word and registers it to the outputs.
- Bubbles collapse: stage 1 advances whenever stage 2 is empty or draining.
- Encodings (opcode / funct3):
  - ADDI 0010011/000, I-type.
  - LD 0000011/011, I-type.
  - SD 0100011/011, S-type.
  - BEQ 1100011/000, B-type.
  - BNE 1100011/001, B-type.
  - LUI 0110111, U-type.
  - JAL 1101111, J-type.
  - Unused register fields are 0: rs2 for I-type; rd for S/B-type; rs1/rs2 for U/J-type.
- Immediate placement:
  - I: imm[11:0] -> [31:20].
  - S: imm[11:5] -> [31:25], imm[4:0] -> [11:7].
  - B: imm[12] -> [31], imm[10:5] -> [30:25], imm[4:1] -> [11:8], imm[11] -> [7].
  - U: imm[31:12] -> [31:12].
  - J: imm[20] -> [31], imm[10:1] -> [30:21], imm[11] -> [20], imm[19:12] -> [19:12].
- Immediate bits above each format's range are truncated in the encoding.
- Reserved op 7: out_instr=0, out_err=1, regardless of the optional feature.
- Simultaneous output accept and new input accept in the same cycle: both take effect with no bubble.
- Ordering: strictly FIFO; no reordering, no drops.

Optional Feature:
- Macro IMM_ENC_RANGE_CHECK_EN.
- Defined: out_err=1 in any of these cases:
  - I/S immediate outside [-2048, 2047].
  - B immediate outside [-4096, 4094] or imm[0]=1.
  - J immediate outside [-1048576, 1048574] or imm[0]=1.
  - U immediate with imm[11:0]!=0 or imm[63:31] not all equal.
  - The word is still emitted with truncated fields.
- Undefined: no checker logic is compiled; out_err is set only for reserved op 7.

Decomposition:
- Package imm_enc_pkg holds:
  - op_e enum.
  - Opcode and funct3 localparams.
  - Format enum fmt_e (I, S, B, U, J).
  - Function op_to_fmt.
- One natural sub-module: imm_range_chk (combinational, fmt + imm -> err). It is instantiated only under IMM_ENC_RANGE_CHECK_EN.

Test Plan:
- ADDI rd=5 rs1=6 imm=-1 -> out_instr=0xFFF30293, out_err=0, out_valid exactly 2 edges after accept.
- BEQ rs1=1 rs2=2 imm=8 -> 0x00208463; LUI rd=10 imm=0x12345000 -> 0x12345537; SD rs1=2 rs2=8 imm=16 -> 0x00813823.
- With IMM_ENC_RANGE_CHECK_EN: BNE imm=3 -> out_err=1; ADDI imm=2048 -> out_err=1 with imm field 0x800; ADDI imm=2047 -> out_err=0. Without the macro, all three give out_err=0.
- Backpressure: hold out_ready=0 and offer 4 back-to-back requests. Exactly 2 are accepted, then in_ready=0. Release out_ready: all 4 words emerge in order, one per cycle, outputs stable while stalled.
- Reset mid-stream: drop reset_n with out_valid=1 between edges. out_valid, out_instr and out_err go 0 immediately. After release there are no stale words.
- Reserved op 7 -> out_instr=0, out_err=1 in both builds.
